// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, centre-sampling bit FSM and a
// one-entry valid/ready holding register with framing-error and overrun pulses.
module uart_rx #(
  parameter int CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  logic          rx_meta_r;
  logic          rx_sync_r;
  logic          rx_prev_r;
  state_t        state_r;
  state_t        state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [2:0]    bitn_r;
  logic [7:0]    shreg_r;

  logic          tick_s;
  logic          start_edge_s;
  logic          load_half_s;
  logic          load_full_s;
  logic          shift_s;
  logic          bitn_clear_s;
  logic          deliver_s;
  logic          stop_bad_s;
  logic          accept_s;

  assign tick_s       = (state_r != ST_IDLE) && (cnt_r == CNT_ZERO);
  assign start_edge_s = rx_prev_r && !rx_sync_r;
  assign accept_s     = !rx_valid || rx_ready;

  // Synchroniser chain plus one-cycle history for start-edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_edge_s) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) begin
          // A start bit that is high again at mid-bit is a glitch.
          state_nxt_s = rx_sync_r ? ST_IDLE : ST_DATA;
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s && (bitn_r == 3'd7)) begin
          state_nxt_s = ST_STOP;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (tick_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode: datapath controls for counter, shifter and delivery.
  always_comb begin
    load_half_s  = 1'b0;
    load_full_s  = 1'b0;
    shift_s      = 1'b0;
    bitn_clear_s = 1'b0;
    deliver_s    = 1'b0;
    stop_bad_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        load_half_s = start_edge_s;
      end
      ST_START: begin
        if (tick_s && !rx_sync_r) begin
          load_full_s  = 1'b1;
          bitn_clear_s = 1'b1;
        end else begin
          load_full_s  = 1'b0;
          bitn_clear_s = 1'b0;
        end
      end
      ST_DATA: begin
        shift_s     = tick_s;
        load_full_s = tick_s;
      end
      ST_STOP: begin
        // Leaving at mid-stop-bit lets an immediately following start edge be seen.
        deliver_s  = tick_s && rx_sync_r;
        stop_bad_s = tick_s && !rx_sync_r;
      end
      default: begin
        load_half_s = 1'b0;
      end
    endcase
  end

  // Bit timer: reloads on start detection and at every sample point.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r <= CNT_ZERO;
    end else if (load_half_s) begin
      cnt_r <= HALF_LOAD;
    end else if (load_full_s) begin
      cnt_r <= FULL_LOAD;
    end else if ((state_r != ST_IDLE) && (cnt_r != CNT_ZERO)) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= CNT_ZERO;
    end
  end

  // Data bit index and LSB-first shift register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bitn_r  <= 3'd0;
      shreg_r <= 8'h00;
    end else if (bitn_clear_s) begin
      bitn_r  <= 3'd0;
      shreg_r <= shreg_r;
    end else if (shift_s) begin
      bitn_r  <= bitn_r + 3'd1;
      shreg_r <= {rx_sync_r, shreg_r[7:1]};
    end else begin
      bitn_r  <= bitn_r;
      shreg_r <= shreg_r;
    end
  end

  // Holding register: consumer-paced, never stalls the receiver.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
    end else if (deliver_s && accept_s) begin
      rx_data  <= shreg_r;
      rx_valid <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_data  <= rx_data;
      rx_valid <= 1'b0;
    end else begin
      rx_data  <= rx_data;
      rx_valid <= rx_valid;
    end
  end

  // Single-cycle error flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad_s;
      overrun   <= deliver_s && !accept_s;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx: a frame-level model queues expected
// events per frame sent; a negedge monitor pops and compares them as they appear.
module tb_uart_rx;

  localparam int CLK_DIV = 8;
  localparam int K_DATA  = 0;
  localparam int K_FERR  = 1;
  localparam int K_OVR   = 2;
  localparam int LAT_NOM = 2 + CLK_DIV / 2 + 9 * CLK_DIV;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       resetn;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  exp_t       exp_q[$];
  int         n_cmp;
  int         n_err;
  int         cyc;
  int         start_cyc;
  int         valid_cyc;
  bit         model_full;

  uart_rx #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_event(input int kind, input logic [7:0] data);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind %0d data %02h, expected none (cycle %0d)",
               kind, data, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == K_DATA && e.data != data)) begin
        n_err++;
        $display("FAIL event: got kind %0d data %02h, expected kind %0d data %02h (cycle %0d)",
                 kind, data, e.kind, e.data, cyc);
      end
    end
  endtask

  // Monitor: new byte presented, error pulses, and data stability while held.
  initial begin
    bit         prev_valid;
    bit         prev_hs;
    logic [7:0] prev_data;
    prev_valid = 1'b0;
    prev_hs    = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
        prev_data  = 8'h00;
      end else begin
        if (rx_valid && (!prev_valid || prev_hs)) begin
          valid_cyc = cyc;
          check_event(K_DATA, rx_data);
        end
        if (frame_err) check_event(K_FERR, 8'h00);
        if (overrun)   check_event(K_OVR, 8'h00);
        if (rx_valid && prev_valid && !prev_hs) check("rx_data_stable", int'(rx_data), int'(prev_data));
        prev_valid = rx_valid;
        prev_hs    = rx_valid && rx_ready;
        prev_data  = rx_data;
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CLK_DIV) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Caller is aligned #1 after a posedge.
  task automatic send_frame(input logic [7:0] data, input logic stop, input int gap_bits);
    exp_t e;
    e.data = data;
    if (!stop) begin
      e.kind = K_FERR;
    end else if (model_full) begin
      e.kind = K_OVR;
    end else begin
      e.kind = K_DATA;
      if (!rx_ready) model_full = 1'b1;
    end
    exp_q.push_back(e);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    drive_bit(stop);
    for (int g = 0; g < gap_bits; g++) drive_bit(1'b1);
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d events still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready   = 1'b0;
    model_full = 1'b0;
    @(negedge clk);
    check("valid_after_consume", int'(rx_valid), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] b;
    logic       s;
    int         g;
    n_cmp      = 0;
    n_err      = 0;
    valid_cyc  = 0;
    start_cyc  = 0;
    model_full = 1'b0;
    rx         = 1'b1;
    rx_ready   = 1'b0;
    resetn     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rx_data", int'(rx_data), 8'h00);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_overrun", int'(overrun), 0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    drive_bit(1'b1);

    // Single byte, consumer not ready: latency and hold.
    send_frame(8'hA5, 1'b1, 1);
    wait_drain(200);
    check("latency_lo", int'(valid_cyc - start_cyc >= LAT_NOM - 1), 1);
    check("latency_hi", int'(valid_cyc - start_cyc <= LAT_NOM + 1), 1);
    check("a5_data", int'(rx_data), 8'hA5);
    check("a5_valid_held", int'(rx_valid), 1);
    consume();

    // Back-to-back frames, consumer always ready.
    rx_ready = 1'b1;
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 1);
    wait_drain(200);
    rx_ready = 1'b0;
    drive_bit(1'b1);

    // Overrun: second byte completes while first is still held.
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 1);
    wait_drain(200);
    check("overrun_keeps_old", int'(rx_data), 8'h11);
    consume();

    // Framing error, then line held low: no retrigger.
    send_frame(8'h3C, 1'b0, 0);
    rx = 1'b0;
    repeat (4 * CLK_DIV) @(posedge clk);
    #1;
    wait_drain(200);
    check("ferr_no_valid", int'(rx_valid), 0);
    drive_bit(1'b1);
    drive_bit(1'b1);

    // Short glitch on idle line.
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("glitch_no_valid", int'(rx_valid), 0);

    // Reset mid-frame, then a clean frame after idle.
    rx_ready = 1'b1;
    b = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(b[i]);
    resetn     = 1'b0;
    rx         = 1'b1;
    model_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) drive_bit(1'b1);
    check("reset_abort_valid", int'(rx_valid), 0);
    send_frame(8'hC3, 1'b1, 1);
    wait_drain(200);
    check("c3_data", int'(rx_data), 8'hC3);

    // Randomised frames with occasional framing errors and random gaps.
    for (int k = 0; k < 24; k++) begin
      b = 8'($urandom);
      s = ($urandom_range(0, 5) != 0);
      g = s ? int'($urandom_range(0, 2)) : 1 + int'($urandom_range(0, 1));
      send_frame(b, s, g);
    end
    wait_drain(400);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
